// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_state_e;

    localparam int RETRY_W = 8;

    localparam int DEF_RST_PULSE_CYCLES    = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;

    localparam int CNT_W_MIN = 17;

    // Width able to count up to (largest parameter - 1), never below CNT_W_MIN.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = $clog2(m);
        return (w < CNT_W_MIN) ? CNT_W_MIN : w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, asynchronous reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    // Two back-to-back flops to settle metastability on the async input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses pll_areset, filters locked, then releases
// sys_reset. Lock loss or soft_reset restarts the sequence.
// Optional build macro PLL_RESET_WATCHDOG_EN adds a lock timeout that
// restarts the PLL if WAIT_LOCK+STABLE lasts too long.
module pll_reset_ctrl
    import pll_rst_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES
) (
    input  logic               inclk0,
    input  logic               areset,
    input  logic               pll_locked,
    input  logic               soft_reset,
    output logic               pll_areset,
    output logic               sys_reset,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [1:0]         state
);

    localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

    pll_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           retry_inc;
    logic           locked_s;

    sync_2ff u_lock_sync (
        .clk (inclk0),
        .rst (areset),
        .d   (pll_locked),
        .q   (locked_s)
    );

`ifdef PLL_RESET_WATCHDOG_EN
    localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wd_q;
    logic          wd_hit;

    // Timeout counter: zeroed while the PLL is held in reset, runs during
    // WAIT_LOCK and STABLE (glitch returns to WAIT_LOCK do not clear it).
    always_ff @(posedge inclk0 or posedge areset) begin
        if (areset)
            wd_q <= '0;
        else if (state_q == PLL_RST)
            wd_q <= '0;
        else if (state_q == WAIT_LOCK || state_q == STABLE)
            wd_q <= wd_q + CW'(1);
    end

    assign wd_hit = (wd_q == TO_LAST);
`endif

    // Next-state and shared counter; soft_reset overrides everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_inc = 1'b0;
        if (soft_reset) begin
            state_d   = PLL_RST;
            cnt_d     = '0;
            retry_inc = 1'b1;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                WAIT_LOCK: begin
                    cnt_d = '0;
                    if (locked_s) state_d = STABLE;
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STB_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RUN: begin
                    cnt_d = '0;
                    if (!locked_s) begin
                        state_d   = PLL_RST;
                        retry_inc = 1'b1;
                    end
                end
                default: begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                end
            endcase
`ifdef PLL_RESET_WATCHDOG_EN
            // Timeout loses only to a simultaneous STABLE->RUN release.
            if (wd_hit && (state_q == WAIT_LOCK || state_q == STABLE) && state_d != RUN) begin
                state_d   = PLL_RST;
                cnt_d     = '0;
                retry_inc = 1'b1;
            end
`endif
        end
    end

    // State, counter and registered outputs; outputs follow the next state so
    // sys_reset/pll_areset change on the same edge as the transition.
    always_ff @(posedge inclk0 or posedge areset) begin
        if (areset) begin
            state_q    <= PLL_RST;
            cnt_q      <= '0;
            pll_areset <= 1'b1;
            sys_reset  <= 1'b1;
            retry_cnt  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pll_areset <= (state_d == PLL_RST);
            sys_reset  <= (state_d != RUN);
            if (retry_inc && retry_cnt != RETRY_MAX)
                retry_cnt <= retry_cnt + RETRY_W'(1);
        end
    end

    assign state = state_q;

endmodule

// File: doc/pll_reset_ctrl.md
# pll_reset_ctrl

Reset sequencer that sits beside `sys_pll` on the raw board clock. It drives the PLL's `areset` with a pulse of guaranteed width, then waits for `locked` and filters it. Once lock is stable it releases a single system reset for the PLL-clocked logic. On lock loss or a soft request it re-asserts system reset and restarts the PLL.

## Interface
Parameters:
- `RST_PULSE_CYCLES`, 16: width of the `pll_areset` pulse, in `inclk0` cycles (≥1).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before release (≥1).
- `LOCK_TIMEOUT_CYCLES`, 65536: cycles allowed in WAIT_LOCK plus STABLE before a retry (watchdog build only).

Ports:
- `inclk0`, in, 1: board reference clock; the only clock.
- `areset`, in, 1: asynchronous, active-high reset.
- `pll_locked`, in, 1: PLL `locked`; asynchronous to `inclk0`.
- `soft_reset`, in, 1: synchronous one-cycle request to restart the PLL.
- `pll_areset`, out, 1: to PLL `areset`; registered, active-high.
- `sys_reset`, out, 1: system reset, active-high. Asserts asynchronously with `areset`; releases only on an `inclk0` edge.
- `retry_cnt`, out, 8: count of PLL restarts since `areset`; saturates at 255.
- `state`, out, 2: current FSM state, for debug.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `locked_s`.
- FSM states: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3. One shared counter `cnt`, 17 bits minimum, sized to the largest parameter.
- Reset values: state=PLL_RST, `cnt`=0, `pll_areset`=1, `sys_reset`=1, `retry_cnt`=0, synchronizer flops=0.
- PLL_RST: `pll_areset`=1, `sys_reset`=1. `cnt` counts up. At `cnt`==RST_PULSE_CYCLES-1, go to WAIT_LOCK and clear `cnt`.
- WAIT_LOCK: `pll_areset`=0. When `locked_s`=1, go to STABLE and clear `cnt`.
- STABLE:
  - `locked_s`=0: return to WAIT_LOCK (glitch filter); the stability count restarts from zero.
  - `cnt`==LOCK_STABLE_CYCLES-1: go to RUN; `sys_reset` falls on that same edge.
- RUN: `sys_reset`=0. If `locked_s`=0, go to PLL_RST; `sys_reset` rises on that same edge.
- `soft_reset`=1 in any state forces PLL_RST with `cnt`=0. It takes priority over every other transition. In PLL_RST it restarts the pulse.
- `retry_cnt` increments on every entry into PLL_RST caused by lock loss, `soft_reset`, or timeout. Entry from `areset` does not count. It saturates at 255.
- `areset` mid-operation: all registers return to their reset values immediately, and a full sequence follows.

## Timing
- `pll_areset` stays high exactly RST_PULSE_CYCLES rising edges after `areset` deasserts or after PLL_RST entry.
- If `pll_locked` rises and holds, `sys_reset` falls exactly LOCK_STABLE_CYCLES+3 edges later: 2 synchronizer edges, 1 edge into STABLE, then the count.
- If lock drops in RUN, `sys_reset` asserts 3 edges after `pll_locked` falls.
- `soft_reset` in RUN: `sys_reset`=1 and `pll_areset`=1 on the next edge.

## Configuration
- `PLL_RESET_WATCHDOG_EN` defined:
  - A timeout counter, cleared on entry into WAIT_LOCK from PLL_RST, runs through WAIT_LOCK and STABLE.
  - When it reaches LOCK_TIMEOUT_CYCLES-1, the FSM enters PLL_RST and counts a retry.
  - A timeout and a STABLE→RUN transition on the same edge resolve to RUN.
- Undefined: the FSM waits for lock indefinitely, and there is no timeout logic.

## Structure
- Package `pll_rst_pkg`:
  - state enum and its encoding (PLL_RST..RUN)
  - `RETRY_W`=8
  - default parameter constants
- Sub-module `sync_2ff`: single-bit, 2-flop synchronizer with asynchronous reset to 0. Instantiated once for `pll_locked`.

## Test plan
Bench parameters: RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32.
- Release `areset`, `pll_locked`=0 → `pll_areset`=1 for exactly 4 edges, then 0; `state`=1; `sys_reset`=1.
- Raise `pll_locked` 10 cycles after release and hold it → `sys_reset` falls exactly 11 edges later; `state`=3; `retry_cnt`=0.
- Pulse `pll_locked` low for 1 cycle during STABLE → `state` returns to 1; `sys_reset` falls 11 edges after `pll_locked` re-rises; `retry_cnt`=0.
- In RUN, drop `pll_locked` → `sys_reset`=1 after 3 edges; `pll_areset` pulses for 4 cycles; `retry_cnt`=1.
- In RUN, assert `soft_reset` for 1 cycle → next edge `state`=0, `pll_areset`=1, `sys_reset`=1; `retry_cnt` increments. Assert `areset` mid-STABLE → all outputs return to reset values immediately.
- With `PLL_RESET_WATCHDOG_EN`, hold `pll_locked`=0 → a new 4-cycle `pll_areset` pulse every 36 cycles; `retry_cnt` rises to 255 and holds there.
